// File: rtl/countdown_timer.sv
// Loadable prescaled down-counter with one-shot and auto-reload modes.
// Provides expiry pulse, sticky expiry flag and stop/resume control.
module countdown_timer #(
    parameter int WIDTH          = 8,
    parameter int PRESCALE_WIDTH = 4
) (
`ifdef USE_POWER_PINS
    inout  wire                      vccd1,
    inout  wire                      vssd1,
`endif
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      LOAD,
    input  logic [WIDTH-1:0]          VALUE,
    input  logic                      START,
    input  logic                      STOP,
    input  logic                      PERIODIC,
    input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
    output logic [WIDTH-1:0]          C,
    output logic                      RUNNING,
    output logic                      EXPIRE,
    output logic                      EXPIRED
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                    state;
    logic [WIDTH-1:0]          reload;
    logic [PRESCALE_WIDTH-1:0] pcnt;
    logic                      tick;

    // >= so that lowering PRESCALE mid-period ticks at once
    assign tick = (pcnt >= PRESCALE);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state   <= IDLE;
            C       <= '0;
            reload  <= '0;
            pcnt    <= '0;
            RUNNING <= 1'b0;
            EXPIRE  <= 1'b0;
            EXPIRED <= 1'b0;
        end else begin
            EXPIRE <= 1'b0;
            if (LOAD) begin
                C       <= VALUE;
                reload  <= VALUE;
                pcnt    <= '0;
                state   <= IDLE;
                RUNNING <= 1'b0;
                EXPIRED <= 1'b0;
            end else if (STOP) begin
                // count and prescale phase hold so START resumes mid-period
                if (state == RUN) begin
                    state   <= IDLE;
                    RUNNING <= 1'b0;
                end
            end else if (START && state != RUN) begin
                EXPIRED <= 1'b0;
                if (C != '0) begin
                    state   <= RUN;
                    RUNNING <= 1'b1;
                end else if (reload != '0) begin
                    C       <= reload;
                    pcnt    <= '0;
                    state   <= RUN;
                    RUNNING <= 1'b1;
                end else begin
                    EXPIRE  <= 1'b1;
                    EXPIRED <= 1'b1;
                    state   <= DONE;
                    RUNNING <= 1'b0;
                end
            end else if (state == RUN) begin
                if (tick) begin
                    pcnt <= '0;
                    if (C > WIDTH'(1)) begin
                        C <= C - WIDTH'(1);
                    end else begin
                        EXPIRE  <= 1'b1;
                        EXPIRED <= 1'b1;
                        if (PERIODIC && reload != '0) begin
                            C <= reload;
                        end else begin
                            C       <= '0;
                            state   <= DONE;
                            RUNNING <= 1'b0;
                        end
                    end
                end else begin
                    pcnt <= pcnt + PRESCALE_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer.
// Checks reset, one-shot, periodic, prescale, control and zero-reload cases.
module tb_countdown_timer;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       LOAD;
    logic [7:0] VALUE;
    logic       START;
    logic       STOP;
    logic       PERIODIC;
    logic [3:0] PRESCALE;
    logic [7:0] C;
    logic       RUNNING;
    logic       EXPIRE;
    logic       EXPIRED;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef USE_POWER_PINS
    wire vccd1 = 1'b1;
    wire vssd1 = 1'b0;
`endif

    countdown_timer #(
        .WIDTH(8),
        .PRESCALE_WIDTH(4)
    ) dut (
`ifdef USE_POWER_PINS
        .vccd1(vccd1),
        .vssd1(vssd1),
`endif
        .CLK(CLK),
        .RESET(RESET),
        .LOAD(LOAD),
        .VALUE(VALUE),
        .START(START),
        .STOP(STOP),
        .PERIODIC(PERIODIC),
        .PRESCALE(PRESCALE),
        .C(C),
        .RUNNING(RUNNING),
        .EXPIRE(EXPIRE),
        .EXPIRED(EXPIRED)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] ec,
                           input logic er, input logic ee, input logic ed);
        chk({tag, ".C"}, 32'(C), 32'(ec));
        chk({tag, ".RUNNING"}, 32'(RUNNING), 32'(er));
        chk({tag, ".EXPIRE"}, 32'(EXPIRE), 32'(ee));
        chk({tag, ".EXPIRED"}, 32'(EXPIRED), 32'(ed));
    endtask

    initial begin
        RESET    = 1'b1;
        LOAD     = 1'b0;
        VALUE    = 8'h00;
        START    = 1'b0;
        STOP     = 1'b0;
        PERIODIC = 1'b0;
        PRESCALE = 4'd0;
        step();
        chk_all("rst_init", 8'h00, 0, 0, 0);
        RESET = 1'b0;
        step();

        // 1: reset mid-operation
        LOAD = 1'b1; VALUE = 8'h55;
        step();
        LOAD = 1'b0;
        chk_all("t1_load", 8'h55, 0, 0, 0);
        START = 1'b1;
        step();
        START = 1'b0;
        chk_all("t1_run", 8'h55, 1, 0, 0);
        step();
        chk_all("t1_dec", 8'h54, 1, 0, 0);
        #2;
        RESET = 1'b1;
        #1;
        chk_all("t1_async", 8'h00, 0, 0, 0);
        step();
        step();
        chk_all("t1_held", 8'h00, 0, 0, 0);
        RESET = 1'b0;
        step();
        chk_all("t1_rel", 8'h00, 0, 0, 0);
        step();
        chk_all("t1_rel2", 8'h00, 0, 0, 0);

        // 2: one-shot 3,2,1,0
        LOAD = 1'b1; VALUE = 8'd3;
        step();
        LOAD = 1'b0;
        START = 1'b1;
        step();
        START = 1'b0;
        chk_all("t2_c3", 8'd3, 1, 0, 0);
        step();
        chk_all("t2_c2", 8'd2, 1, 0, 0);
        step();
        chk_all("t2_c1", 8'd1, 1, 0, 0);
        step();
        chk_all("t2_c0", 8'd0, 0, 1, 1);
        step();
        chk_all("t2_after", 8'd0, 0, 0, 1);
        step();
        chk_all("t2_sticky", 8'd0, 0, 0, 1);

        // 3: periodic 2,1,2,1
        LOAD = 1'b1; VALUE = 8'd2; PERIODIC = 1'b1;
        step();
        LOAD = 1'b0;
        chk_all("t3_load", 8'd2, 0, 0, 0);
        START = 1'b1;
        step();
        START = 1'b0;
        chk_all("t3_c2a", 8'd2, 1, 0, 0);
        step();
        chk_all("t3_c1a", 8'd1, 1, 0, 0);
        step();
        chk_all("t3_c2b", 8'd2, 1, 1, 1);
        step();
        chk_all("t3_c1b", 8'd1, 1, 0, 1);
        step();
        chk_all("t3_c2c", 8'd2, 1, 1, 1);
        STOP = 1'b1;
        step();
        STOP = 1'b0;
        chk_all("t3_stop", 8'd2, 0, 0, 1);

        // 4: prescale 3, expiry 8 cycles after RUNNING rises
        LOAD = 1'b1; VALUE = 8'd2; PERIODIC = 1'b0; PRESCALE = 4'd3;
        step();
        LOAD = 1'b0;
        START = 1'b1;
        step();
        START = 1'b0;
        chk_all("t4_start", 8'd2, 1, 0, 0);
        for (int i = 1; i <= 8; i++) begin
            logic [7:0] ec;
            ec = (i < 4) ? 8'd2 : (i < 8) ? 8'd1 : 8'd0;
            step();
            chk($sformatf("t4_c%0d", i), 32'(C), 32'(ec));
            chk($sformatf("t4_e%0d", i), 32'(EXPIRE), 32'(i == 8));
        end
        chk("t4_run_end", 32'(RUNNING), 32'd0);

        // lowering PRESCALE mid-period ticks immediately
        LOAD = 1'b1; VALUE = 8'd3; PRESCALE = 4'd7;
        step();
        LOAD = 1'b0;
        START = 1'b1;
        step();
        START = 1'b0;
        step();
        step();
        step();
        chk("t4b_hold", 32'(C), 32'd3);
        PRESCALE = 4'd1;
        step();
        chk("t4b_lower", 32'(C), 32'd2);
        PRESCALE = 4'd0;

        // 5: control conflicts
        LOAD = 1'b1; VALUE = 8'd7;
        step();
        LOAD = 1'b0;
        chk_all("t5_load", 8'd7, 0, 0, 0);
        START = 1'b1;
        step();
        START = 1'b0;
        step();
        step();
        chk_all("t5_c5", 8'd5, 1, 0, 0);
        STOP = 1'b1;
        step();
        STOP = 1'b0;
        chk_all("t5_stop", 8'd5, 0, 0, 0);
        step();
        chk_all("t5_hold", 8'd5, 0, 0, 0);
        START = 1'b1;
        step();
        START = 1'b0;
        chk_all("t5_resume", 8'd5, 1, 0, 0);
        step();
        chk_all("t5_c4", 8'd4, 1, 0, 0);
        START = 1'b1; STOP = 1'b1;
        step();
        START = 1'b0; STOP = 1'b0;
        chk_all("t5_both", 8'd4, 0, 0, 0);
        START = 1'b1;
        step();
        START = 1'b0;
        step();
        chk_all("t5_c3", 8'd3, 1, 0, 0);
        LOAD = 1'b1; VALUE = 8'd9;
        step();
        LOAD = 1'b0;
        chk_all("t5_reload", 8'd9, 0, 0, 0);
        step();
        chk_all("t5_idle", 8'd9, 0, 0, 0);

        // 6: zero reload
        LOAD = 1'b1; VALUE = 8'd0;
        step();
        LOAD = 1'b0;
        START = 1'b1;
        step();
        START = 1'b0;
        chk_all("t6_p1", 8'd0, 0, 1, 1);
        step();
        chk_all("t6_p1end", 8'd0, 0, 0, 1);
        START = 1'b1;
        step();
        START = 1'b0;
        chk_all("t6_p2", 8'd0, 0, 1, 1);
        step();
        chk_all("t6_p2end", 8'd0, 0, 0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Loadable down-counting timer that complements the team's 8-bit up-counter.
- Counts a loaded value down to zero at a prescaled tick rate and signals expiry.
- Runs either one-shot or periodic (auto-reload), and supports stop/resume.
- Used as a programmable timeout or periodic-event source in the user area; power pins are provided under USE_POWER_PINS, as on the other user-area blocks.

Parameters:
WIDTH, 8, width of the count, VALUE and C
PRESCALE_WIDTH, 4, width of the PRESCALE input and the internal prescale counter

Ports:
CLK  input  1  clock
RESET  input  1  reset (asynchronous, active-high)
LOAD  input  1  load VALUE into count and reload registers; stops timer
VALUE  input  WIDTH  value captured on LOAD
START  input  1  start or resume counting
STOP  input  1  pause counting
PERIODIC  input  1  1 = auto-reload on expiry, 0 = one-shot
PRESCALE  input  PRESCALE_WIDTH  tick every PRESCALE+1 cycles
C  output  WIDTH  current count
RUNNING  output  1  high while in RUN
EXPIRE  output  1  single-cycle pulse on expiry
EXPIRED  output  1  sticky expiry flag

Behaviour:
- Reset and clock: reset RESET, asynchronous, active-high; clock CLK.
  - While RESET is high, all of the following are 0: C, reload register, prescale counter, RUNNING, EXPIRE, EXPIRED; state = IDLE.
  - All outputs are registered.
- States: IDLE, RUN, DONE. RUNNING = (state == RUN).
- Priority per cycle: LOAD > STOP > START > tick.
- LOAD (any state):
  - C <= VALUE, reload <= VALUE, prescale counter <= 0.
  - State <= IDLE; EXPIRED <= 0; EXPIRE <= 0.
- STOP in RUN:
  - State <= IDLE.
  - C and prescale counter hold, so a later START resumes mid-period.
  - STOP in IDLE or DONE has no effect.
- START in IDLE or DONE (and no LOAD/STOP that cycle):
  - C != 0: state <= RUN.
  - C == 0 and reload != 0: C <= reload, prescale counter <= 0, state <= RUN.
  - C == 0 and reload == 0: EXPIRE <= 1 for one cycle, EXPIRED <= 1, state <= DONE.
  - In all cases START clears EXPIRED before any new expiry sets it.
- START in RUN: ignored.
- Prescaler (RUN only):
  - tick = (prescale counter >= PRESCALE). On tick the counter returns to 0; otherwise it increments.
  - PRESCALE is sampled every cycle; the >= compare makes lowering PRESCALE mid-period produce a tick immediately.
  - The counter holds outside RUN.
- On tick in RUN:
  - C > 1: C <= C - 1.
  - C == 1, PERIODIC = 0: C <= 0, state <= DONE, EXPIRE <= 1 (same cycle C shows 0), EXPIRED <= 1.
  - C == 1, PERIODIC = 1: C <= reload (0 is never shown), stays RUN, EXPIRE <= 1, EXPIRED <= 1.
  - Period is reload × (PRESCALE+1) cycles. PERIODIC is sampled at expiry only.
- Latency, with PRESCALE = 0: START sampled at edge k → RUNNING = 1 after edge k → first decrement at edge k+1.
- EXPIRE is high for exactly one cycle per expiry and is 0 at every other time.
- Wrap-around: none. C never decrements below 0 and never underflows to all-ones.
- RESET asserted mid-RUN immediately forces reset values; counting resumes only after a new LOAD/START.

Test Plan:
1. Reset mid-operation: LOAD 8'h55, START, assert RESET for 2 cycles → C=0, RUNNING=0, EXPIRE=0, EXPIRED=0 while asserted and after release.
2. One-shot: LOAD 3, PRESCALE 0, PERIODIC 0, START → C sequence 3,2,1,0 on consecutive cycles; EXPIRE=1 only in the cycle C=0; RUNNING drops that cycle; EXPIRED stays 1 until the next START or LOAD.
3. Periodic: LOAD 2, PERIODIC 1, PRESCALE 0, START → C 2,1,2,1,…; EXPIRE pulses every 2 cycles; RUNNING stays 1.
4. Prescale: LOAD 2, PRESCALE 3, START → C decrements every 4 cycles; EXPIRE 8 cycles after RUNNING rises.
5. Control conflicts:
   - STOP while C=5 → C holds, RUNNING=0; START → resumes from 5.
   - START+STOP in the same cycle while running → stops.
   - LOAD 9 during RUN → C=9, IDLE, EXPIRED=0.
6. Zero reload: LOAD 0, START → one-cycle EXPIRE, EXPIRED=1, state DONE, C=0; repeat START → another single pulse.
